mandelbrot_render_sequencer: RTL and testbench

- Parametrised frame sequencer that drives NUM_CORES mandelbrot engines in parallel and streams results, in raster order, into the framebuffer write port.
- Owns the pixel raster counter, the RP2040 configuration shift register, and the framebuffer write handshake.
- Sits between the top-level IO mux and the engine/framebuffer instances; replaces the single-core start/wait/write controller.

---
 rtl/mandelbrot_render_sequencer.sv | 153 +++++++++++++++
 tb/tb_mandelbrot_render_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_render_sequencer.sv
// Frame sequencer: dispatches raster pixels round-robin to NUM_CORES engines, writes results in raster order.
// Optional macro RENDER_PERF_EN adds the frame_cycles performance counter output.
module mandelbrot_render_sequencer #(
   parameter int NUM_CORES = 2,
   parameter int H_PIXELS  = 160,
   parameter int V_PIXELS  = 120,
   parameter int OUT_WIDTH = 4,
   parameter int CFG_WIDTH = 33,
   localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1,
   localparam int YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic                           abort,
   input  logic                           cfg_shift_en,
   input  logic                           cfg_data,
   output logic [CFG_WIDTH-1:0]           cfg_out,
   output logic [XW-1:0]                  px_x,
   output logic [YW-1:0]                  px_y,
   output logic [NUM_CORES-1:0]           core_run,
   input  logic [NUM_CORES-1:0]           core_running,
   input  logic [NUM_CORES*OUT_WIDTH-1:0] core_ctr,
   output logic                           fb_write_mode,
   output logic                           fb_reset_wr_ptr,
   input  logic                           fb_wr_ready,
   output logic                           fb_wr_valid,
   output logic [OUT_WIDTH-1:0]           fb_wr_data,
   output logic                           busy,
   output logic                           frame_done
`ifdef RENDER_PERF_EN
   ,
   output logic [31:0]                    frame_cycles
`endif
);

   localparam int TOTAL = H_PIXELS * V_PIXELS;
   localparam int NW    = $clog2(TOTAL + 1);
   localparam int PW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN} state_t;

   state_t               state, state_nxt;
   logic [NUM_CORES-1:0] pending, held, run_q, cap, pending_nxt, held_nxt;
   logic [OUT_WIDTH-1:0] held_data [NUM_CORES];
   logic [PW-1:0]        dptr, rptr;
   logic [NW-1:0]        disp_cnt, ret_cnt;
   logic                 dispatch, retire, last_retire, frame_abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      frame_abort = abort && (state != S_IDLE);
      // abort suppresses both dispatch and retire in the cycle it is seen
      dispatch    = (state == S_RUN) && !abort && (disp_cnt < NW'(TOTAL)) &&
                    !pending[dptr] && !held[dptr];
      retire      = (state == S_RUN) && !abort && held[rptr] && fb_wr_ready;
      last_retire = retire && (ret_cnt == NW'(TOTAL - 1));
      cap         = pending & run_q & ~core_running;
      pending_nxt = pending & ~cap;
      held_nxt    = held | cap;
      if (dispatch) pending_nxt[dptr] = 1'b1;
      if (retire)   held_nxt[rptr]    = 1'b0;
      if (frame_abort || state == S_CLR) begin
         pending_nxt = '0;
         held_nxt    = '0;
      end
      core_run = '0;
      if (dispatch) core_run[dptr] = 1'b1;
      fb_wr_valid     = retire;
      fb_wr_data      = retire ? held_data[rptr] : '0;
      fb_reset_wr_ptr = (state == S_CLR);
      busy            = (state != S_IDLE);
      case (state)
         S_IDLE:  if (start) state_nxt = S_CLR;
         S_CLR:   state_nxt = abort ? S_IDLE : S_RUN;
         S_RUN:   if (abort || last_retire) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_out       <= '0;
         run_q         <= '0;
         pending       <= '0;
         held          <= '0;
         frame_done    <= 1'b0;
         fb_write_mode <= 1'b0;
         px_x          <= '0;
         px_y          <= '0;
         dptr          <= '0;
         rptr          <= '0;
         disp_cnt      <= '0;
         ret_cnt       <= '0;
         for (int k = 0; k < NUM_CORES; k++) held_data[k] <= '0;
      end else begin
         run_q      <= core_running;
         pending    <= pending_nxt;
         held       <= held_nxt;
         frame_done <= last_retire;
         if (cfg_shift_en) cfg_out <= {cfg_data, cfg_out[CFG_WIDTH-1:1]};
         for (int k = 0; k < NUM_CORES; k++)
            if (cap[k]) held_data[k] <= core_ctr[k*OUT_WIDTH +: OUT_WIDTH];
         if (state == S_IDLE && start)     fb_write_mode <= 1'b1;
         else if (frame_abort || last_retire) fb_write_mode <= 1'b0;
         if (state == S_CLR) begin
            px_x     <= '0;
            px_y     <= '0;
            dptr     <= '0;
            rptr     <= '0;
            disp_cnt <= '0;
            ret_cnt  <= '0;
         end else begin
            if (dispatch) begin
               disp_cnt <= disp_cnt + 1'b1;
               dptr     <= (dptr == PW'(NUM_CORES - 1)) ? '0 : dptr + 1'b1;
               if (px_x == XW'(H_PIXELS - 1)) begin
                  px_x <= '0;
                  px_y <= (px_y == YW'(V_PIXELS - 1)) ? '0 : px_y + 1'b1;
               end else begin
                  px_x <= px_x + 1'b1;
               end
            end
            if (retire) begin
               ret_cnt <= ret_cnt + 1'b1;
               rptr    <= (rptr == PW'(NUM_CORES - 1)) ? '0 : rptr + 1'b1;
            end
         end
      end
   end

`ifdef RENDER_PERF_EN
   logic [31:0] perf_cnt;

   // perf_cnt holds the number of cycles elapsed since CLR, CLR cycle included
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cnt     <= '0;
         frame_cycles <= '0;
      end else begin
         if (state == S_CLR)      perf_cnt <= 32'd1;
         else if (state == S_RUN) perf_cnt <= perf_cnt + 32'd1;
         if (last_retire) frame_cycles <= perf_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mandelbrot_render_sequencer.sv
// Bench for mandelbrot_render_sequencer: engine models, raster-order scoreboard, randomized latency and backpressure.
module tb_mandelbrot_render_sequencer;
   localparam int NC = 2, H = 4, V = 2, OW = 4, CW = 33;
   localparam int TOTAL = H * V;
   localparam int XW = $clog2(H), YW = $clog2(V);

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic cfg_shift_en = 1'b0, cfg_data = 1'b0, fb_wr_ready = 1'b1;
   logic [CW-1:0]    cfg_out;
   logic [XW-1:0]    px_x;
   logic [YW-1:0]    px_y;
   logic [NC-1:0]    core_run;
   logic [NC-1:0]    core_running = '0;
   logic [NC*OW-1:0] core_ctr = '0;
   logic fb_write_mode, fb_reset_wr_ptr, fb_wr_valid, busy, frame_done;
   logic [OW-1:0]    fb_wr_data;
`ifdef RENDER_PERF_EN
   logic [31:0]      frame_cycles;
`endif

   mandelbrot_render_sequencer #(.NUM_CORES(NC), .H_PIXELS(H), .V_PIXELS(V),
                                 .OUT_WIDTH(OW), .CFG_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_shift_en(cfg_shift_en), .cfg_data(cfg_data), .cfg_out(cfg_out),
      .px_x(px_x), .px_y(px_y), .core_run(core_run), .core_running(core_running),
      .core_ctr(core_ctr), .fb_write_mode(fb_write_mode), .fb_reset_wr_ptr(fb_reset_wr_ptr),
      .fb_wr_ready(fb_wr_ready), .fb_wr_valid(fb_wr_valid), .fb_wr_data(fb_wr_data),
      .busy(busy), .frame_done(frame_done)
`ifdef RENDER_PERF_EN
      , .frame_cycles(frame_cycles)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int exp_q[$];
   int salt = 0, lat_mode = 0, done_cnt = 0, cyc = 0;
   int disp_n = 0, wr_n = 0, clr_cyc = 0, last_wr_cyc = 0, m_core = 0;
   int out_cnt[NC];
   int eng_cnt[NC];
   int eng_val[NC];
   bit rnd_ready = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int pix_val(input int idx);
      return (idx * 5 + salt) % 16;
   endfunction

   function automatic int get_lat(input int k);
      case (lat_mode)
         0:       return 3;
         1:       return (k == 0) ? 10 : 2;
         default: return int'($urandom_range(1, 12));
      endcase
   endfunction

   // Engine models: start on core_run, busy for a latency, result appears as running falls
   initial begin
      for (int k = 0; k < NC; k++) eng_cnt[k] = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            core_running = '0;
            for (int k = 0; k < NC; k++) eng_cnt[k] = 0;
         end else begin
            for (int k = 0; k < NC; k++) begin
               if (eng_cnt[k] > 0) begin
                  eng_cnt[k]--;
                  if (eng_cnt[k] == 0) begin
                     core_running[k] = 1'b0;
                     core_ctr[k*OW +: OW] = OW'(eng_val[k]);
                  end
               end
            end
            for (int k = 0; k < NC; k++) begin
               if (core_run[k]) begin
                  eng_val[k] = pix_val(int'(px_y) * H + int'(px_x));
                  eng_cnt[k] = get_lat(k);
                  core_running[k] = 1'b1;
                  core_ctr[k*OW +: OW] = OW'($urandom);
               end
            end
         end
      end
   end

   // Monitor: dispatch order, write order/data against the scoreboard, frame completion
   initial begin
      for (int k = 0; k < NC; k++) out_cnt[k] = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            if (fb_reset_wr_ptr) begin
               check("clr_queue_full", exp_q.size(), TOTAL);
               check("wr_mode_in_clr", fb_write_mode, 1);
               clr_cyc = cyc;
               disp_n = 0;
               wr_n = 0;
               for (int k = 0; k < NC; k++) out_cnt[k] = 0;
            end
            if (abort && busy) check("abort_gates_outputs", {core_run, fb_wr_valid}, 0);
            if (|core_run) begin
               check("core_run_onehot", $countones(core_run), 1);
               m_core = 0;
               for (int k = 0; k < NC; k++) if (core_run[k]) m_core = k;
               check("dispatch_core", m_core, disp_n % NC);
               check("dispatch_px_x", px_x, disp_n % H);
               check("dispatch_px_y", px_y, disp_n / H);
               check("no_redispatch_while_held", out_cnt[m_core], 0);
               out_cnt[m_core]++;
               disp_n++;
            end
            if (fb_wr_valid) begin
               check("write_with_ready", fb_wr_ready, 1);
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_write: got data %0h expected no write", fb_wr_data);
               end else begin
                  check("write_data", fb_wr_data, exp_q.pop_front());
               end
               out_cnt[wr_n % NC]--;
               wr_n++;
               last_wr_cyc = cyc;
            end
            if (frame_done) begin
               done_cnt++;
               check("frame_done_wr_mode_low", fb_write_mode, 0);
               check("frame_done_all_written", exp_q.size(), 0);
`ifdef RENDER_PERF_EN
               check("frame_cycles", frame_cycles, last_wr_cyc - clr_cyc + 1);
`endif
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame();
      salt = int'($urandom_range(0, 15));
      for (int i = 0; i < TOTAL; i++) exp_q.push_back(pix_val(i));
   endtask

   task automatic wait_done(input int budget);
      int d0;
      bit seen;
      d0 = done_cnt;
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (rnd_ready) fb_wr_ready = ($urandom_range(0, 2) != 0);
         tick();
         if (done_cnt != d0) seen = 1;
      end
      fb_wr_ready = 1'b1;
      check("frame_done_within_budget", seen, 1);
   endtask

   task automatic run_frame();
      push_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(600);
      tick();
   endtask

   task automatic reset_outputs_check();
      check("rst_cfg_out", cfg_out, 0);
      check("rst_ctrl_outs", {core_run, fb_write_mode, fb_reset_wr_ptr, fb_wr_valid, busy, frame_done}, 0);
      check("rst_px", {px_x, px_y}, 0);
      check("rst_wr_data", fb_wr_data, 0);
`ifdef RENDER_PERF_EN
      check("rst_frame_cycles", frame_cycles, 0);
`endif
   endtask

   initial begin
      logic [CW-1:0] pat;
      int d0;
      bit both;
      repeat (3) tick();
      reset_outputs_check();
      rst_n = 1'b1;
      tick();

      // configuration shift, fixed then random pattern
      for (int p = 0; p < 2; p++) begin
         pat = (p == 0) ? 33'h1_5A5A_A5A5 : {$urandom, $urandom};
         for (int i = 0; i < CW; i++) begin
            cfg_shift_en = 1'b1;
            cfg_data = pat[i];
            tick();
         end
         cfg_shift_en = 1'b0;
         tick();
         check("cfg_out", cfg_out, pat);
         check("cfg_no_state_effect", busy, 0);
      end

      lat_mode = 0; run_frame();
      lat_mode = 1; run_frame();
      lat_mode = 2; rnd_ready = 1;
      repeat (4) run_frame();
      rnd_ready = 0;

      // backpressure mid-frame
      push_frame();
      start = 1'b1; tick(); start = 1'b0;
      repeat (5) tick();
      fb_wr_ready = 1'b0;
      repeat (20) tick();
      check("stall_dispatch_idle", {core_run, core_running}, 0);
      check("stall_still_busy", busy, 1);
      fb_wr_ready = 1'b1;
      wait_done(600);
      tick();

      // abort with both cores pending
      lat_mode = 0;
      push_frame();
      start = 1'b1; tick(); start = 1'b0;
      both = 0;
      for (int i = 0; i < 20 && !both; i++) begin
         tick();
         if (core_running == 2'b11) both = 1;
      end
      check("abort_both_running", both, 1);
      d0 = done_cnt;
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort_to_idle", {busy, fb_write_mode}, 0);
      exp_q.delete();
      repeat (15) tick();
      check("abort_no_frame_done", done_cnt, d0);
      run_frame();

      // start held high re-triggers the next frame
      lat_mode = 2;
      push_frame();
      start = 1'b1;
      wait_done(600);
      push_frame();
      tick();
      start = 1'b0;
      wait_done(600);
      tick();

      // async reset mid-frame
      push_frame();
      start = 1'b1; tick(); start = 1'b0;
      repeat (6) tick();
      #2 rst_n = 1'b0;
      #1 reset_outputs_check();
      exp_q.delete();
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      lat_mode = 2;
      run_frame();
      check("frame_done_total", done_cnt, 11);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
